// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   state_t     : transmit FSM state encoding
//   even_parity : XOR of all data bits (one when the count of ones is odd)
//   frame_len   : clock cycles taken by one frame at a given divisor
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int MAX_DATA_WIDTH = 32;

  function automatic logic even_parity(input logic [MAX_DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  // A divisor of 0 runs at one clock per bit, same as a divisor of 1.
  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits,
                                            input int unsigned div);
    return (1 + data_width + parity_en + stop_bits) * ((div == 0) ? 1 : div);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Loadable down-counter that paces serial bits.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture period_m1 as the new bit period and restart the count
//   period_m1  : bit period minus one (clocks per bit - 1)
//   en         : count enable; the counter holds while low
//   bit_tick   : high in the last cycle of each bit period
module baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period_m1,
  input  logic                 en,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] reload;

  // The period is held here so a change on the divisor input only matters at
  // the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= period_m1;
      reload <= period_m1;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload : cnt - 1'b1;
    end
  end

  assign bit_tick = en && !load && (cnt == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// Serial transmitter draining the serial-port FIFO.
// Pops one byte per frame (single-cycle r_en), then drives txd with
// start bit, DATA_WIDTH data bits LSB first, optional even parity and
// STOP_BITS stop bits. Bit time is baud_div clocks, captured at frame load.
//   clk, rst    : clock, synchronous active-high reset
//   tx_en       : allows new frames to be fetched
//   baud_div    : clocks per bit (0 behaves as 1)
//   is_empty    : FIFO empty flag
//   data_avail  : FIFO occupancy, only feeds tx_pending
//   r_data      : FIFO read data, valid the cycle after r_en
//   r_en        : FIFO pop strobe
//   txd         : serial line, idle high
//   tx_busy     : a frame is in progress (FETCH through last stop cycle)
//   frame_done  : pulse in the final cycle of the last stop bit
//   tx_pending  : FIFO holds data or a frame is in progress
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  is_empty,
  input  logic [ADDR_WIDTH:0]   data_avail,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  frame_done,
  output logic                  tx_pending
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic [BCW-1:0]        bit_cnt;
  logic                  stop_cnt;
  logic                  bit_tick;
  logic                  tick_en;
  logic                  last_data;
  logic                  last_stop;
  logic [DIV_WIDTH-1:0]  period_m1;

  assign last_data = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  // max(baud_div, 1) - 1
  assign period_m1 = (baud_div == '0) ? '0 : baud_div - 1'b1;
  assign tick_en   = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);

  baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_LOAD),
    .period_m1 (period_m1),
    .en        (tick_en),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // txd, r_en and frame_done decode straight from registered state so that
  // reset forces the line idle on the same edge, and r_en is a one-cycle
  // pulse in IDLE. r_en is also held off while rst is high.
  always_comb begin
    state_nx   = state;
    r_en       = 1'b0;
    frame_done = 1'b0;
    txd        = 1'b1;
    case (state)
      ST_IDLE: begin
        if (tx_en && !is_empty && !rst) begin
          r_en     = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_START;
      ST_START: begin
        txd = 1'b0;
        if (bit_tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        txd = shift[0];
        if (bit_tick && last_data) state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        txd = par_bit;
        if (bit_tick) state_nx = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick && last_stop) begin
          frame_done = 1'b1;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          shift    <= r_data;
          par_bit  <= even_parity(MAX_DATA_WIDTH'(r_data));
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift   <= shift >> 1;
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick) stop_cnt <= last_stop ? 1'b0 : 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_busy    = (state != ST_IDLE);
  assign tx_pending = (data_avail != '0) || tx_busy;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (8N1 and 8E2), each fed by a queue
// FIFO model. Line activity is logged every cycle and compared against frames
// built from the byte values by a reference model.
module tb_uart_tx_drain;

  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        rst, tx_en;
  logic [15:0] baud_div;
  logic        ren0, ren1, txd0, txd1, busy0, busy1, fd0, fd1, pend0, pend1;
  logic        is_empty0, is_empty1;
  logic [4:0]  avail0 = '0, avail1 = '0;
  logic [7:0]  rdata0 = '0, rdata1 = '0;
  logic        push_v0 = 1'b0, push_v1 = 1'b0;
  logic [7:0]  push_d0 = '0, push_d1 = '0;
  logic [7:0]  q0[$], q1[$];
  int          under0 = 0, under1 = 0;
  int          checks = 0, passed = 0;
  int          cyc = 0;
  logic        txd_log [0:1][0:MAXC-1];
  logic        ren_log [0:1][0:MAXC-1];
  logic        fd_log  [0:1][0:MAXC-1];
  logic        busy_log[0:1][0:MAXC-1];
  logic        exp_q[$];
  logic [7:0]  mb[$];

  always #5 clk = ~clk;

  uart_tx_drain #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DIV_WIDTH(16), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .baud_div(baud_div), .is_empty(is_empty0),
    .data_avail(avail0), .r_data(rdata0), .r_en(ren0), .txd(txd0), .tx_busy(busy0),
    .frame_done(fd0), .tx_pending(pend0));

  uart_tx_drain #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DIV_WIDTH(16), .PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .baud_div(baud_div), .is_empty(is_empty1),
    .data_avail(avail1), .r_data(rdata1), .r_en(ren1), .txd(txd1), .tx_busy(busy1),
    .frame_done(fd1), .tx_pending(pend1));

  // FIFO models: registered read data, pop on r_en, push from the bench.
  always @(posedge clk) begin
    if (ren0) begin
      if (q0.size() > 0) rdata0 <= q0.pop_front();
      else under0 <= under0 + 1;
    end
    if (push_v0) q0.push_back(push_d0);
    avail0 <= 5'(q0.size());
  end
  always @(posedge clk) begin
    if (ren1) begin
      if (q1.size() > 0) rdata1 <= q1.pop_front();
      else under1 <= under1 + 1;
    end
    if (push_v1) q1.push_back(push_d1);
    avail1 <= 5'(q1.size());
  end
  assign is_empty0 = (avail0 == 0);
  assign is_empty1 = (avail1 == 0);

  // Per-cycle log, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (cyc < MAXC) begin
      txd_log[0][cyc] <= txd0;  txd_log[1][cyc] <= txd1;
      ren_log[0][cyc] <= ren0;  ren_log[1][cyc] <= ren1;
      fd_log[0][cyc]  <= fd0;   fd_log[1][cyc]  <= fd1;
      busy_log[0][cyc] <= busy0; busy_log[1][cyc] <= busy1;
    end
    cyc <= cyc + 1;
  end

  // kind: 0 = r_en high, 1 = frame_done high, 2 = txd low
  function automatic logic ev(input int w, input int kind, input int c);
    if (c < 0 || c >= MAXC) return 1'b0;
    case (kind)
      0: return ren_log[w][c] === 1'b1;
      1: return fd_log[w][c] === 1'b1;
      default: return txd_log[w][c] === 1'b0;
    endcase
  endfunction

  function automatic int count_ev(input int w, input int kind, input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (ev(w, kind, c)) n++;
    return n;
  endfunction

  function automatic int first_ev(input int w, input int kind, input int from, input int to);
    for (int c = from; c < to; c++) if (ev(w, kind, c)) return c;
    return -1;
  endfunction

  // Reference line waveform for the bytes in mb: frames separated by the
  // 3-cycle minimum gap, every bit held max(div,1) cycles.
  task automatic build_exp(input int par, input int stop, input int div);
    int d;
    d = (div == 0) ? 1 : div;
    exp_q = {};
    foreach (mb[f]) begin
      logic fb[$];
      int   ones;
      ones = 0;
      if (f > 0) repeat (3) exp_q.push_back(1'b1);
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        fb.push_back(mb[f][i]);
        ones += int'(mb[f][i]);
      end
      if (par != 0) fb.push_back((ones % 2) == 1);
      repeat (stop) fb.push_back(1'b1);
      foreach (fb[k]) repeat (d) exp_q.push_back(fb[k]);
    end
  endtask

  function automatic int stream_errs(input int w, input int st);
    int e = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (st + k >= MAXC || txd_log[w][st + k] !== exp_q[k]) e++;
    return e;
  endfunction

  task automatic push(input int w, input logic [7:0] b);
    @(negedge clk);
    if (w == 0) begin push_v0 = 1'b1; push_d0 = b; end
    else        begin push_v1 = 1'b1; push_d1 = b; end
    @(negedge clk);
    push_v0 = 1'b0;
    push_v1 = 1'b0;
  endtask

  task automatic wait_frames(input int w, input int n, input int budget, output int got);
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clk);
      if ((w == 0) ? fd0 : fd1) got++;
    end
  endtask

  // Loads mb into FIFO w, enables transmission until all frames finish.
  task automatic run_stream(input int w, input int div, output int s, output int st, output int got);
    int d;
    d = (div == 0) ? 1 : div;
    baud_div = 16'(div);
    foreach (mb[i]) push(w, mb[i]);
    s = cyc;
    tx_en = 1'b1;
    wait_frames(w, mb.size(), mb.size() * (12 * d + 3) + 100, got);
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    st = first_ev(w, 2, s, cyc);
    build_exp(w, (w != 0) ? 2 : 1, div);
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_en = 1'b0; baud_div = 16'd4;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (txd0 !== 1'b1)  $display("FAIL reset_txd0: got %b expected 1", txd0);  else passed++;
    checks++; if (ren0 !== 1'b0)  $display("FAIL reset_ren0: got %b expected 0", ren0);  else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b expected 0", busy0); else passed++;
    checks++; if (fd0 !== 1'b0)   $display("FAIL reset_fd0: got %b expected 0", fd0);    else passed++;
    checks++; if (pend0 !== 1'b0) $display("FAIL reset_pend0: got %b expected 0", pend0); else passed++;
    checks++; if (txd1 !== 1'b1)  $display("FAIL reset_txd1: got %b expected 1", txd1);  else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b expected 0", busy1); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    int s, st, got, r;
    mb = {}; mb.push_back(8'hA5);
    run_stream(0, 4, s, st, got);
    r = first_ev(0, 0, s, cyc);
    checks++; if (got !== 1) $display("FAIL single_done: got %0d frames expected 1", got); else passed++;
    checks++; if (count_ev(0, 0, s, cyc) !== 1) $display("FAIL single_ren: got %0d pulses expected 1", count_ev(0, 0, s, cyc)); else passed++;
    checks++; if (st - r !== 3) $display("FAIL single_latency: got %0d cycles expected 3", st - r); else passed++;
    checks++; if (stream_errs(0, st) !== 0) $display("FAIL single_wave: got %0d bad cycles expected 0", stream_errs(0, st)); else passed++;
    checks++; if (!ev(0, 1, st + 39)) $display("FAIL single_fd_pos: got 0 at cycle 39 expected 1"); else passed++;
    checks++; if (count_ev(0, 1, s, cyc) !== 1) $display("FAIL single_fd_cnt: got %0d expected 1", count_ev(0, 1, s, cyc)); else passed++;
    checks++; if (busy_log[0][st + 39] !== 1'b1 || busy_log[0][st + 40] !== 1'b0)
      $display("FAIL single_busy: got %b%b expected 10", busy_log[0][st + 39], busy_log[0][st + 40]); else passed++;
  endtask

  task automatic test_back_to_back;
    int s, st, got, gap;
    logic [7:0] dec;
    mb = {}; mb.push_back(8'h01); mb.push_back(8'h02);
    run_stream(0, 2, s, st, got);
    checks++; if (count_ev(0, 0, s, cyc) !== 2) $display("FAIL b2b_ren: got %0d expected 2", count_ev(0, 0, s, cyc)); else passed++;
    checks++; if (stream_errs(0, st) !== 0) $display("FAIL b2b_wave: got %0d bad cycles expected 0", stream_errs(0, st)); else passed++;
    gap = first_ev(0, 2, st + 20, cyc) - (st + 20);
    checks++; if (gap !== 3) $display("FAIL b2b_gap: got %0d expected 3", gap); else passed++;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) dec[i] = txd_log[0][st + k * 23 + 2 * (1 + i) + 1];
      checks++; if (dec !== 8'(k + 1)) $display("FAIL b2b_byte%0d: got %h expected %h", k, dec, 8'(k + 1)); else passed++;
    end
  endtask

  task automatic test_parity;
    int s, st, got;
    mb = {}; mb.push_back(8'h07); mb.push_back(8'h03);
    run_stream(1, 3, s, st, got);
    checks++; if (count_ev(1, 0, s, cyc) !== 2) $display("FAIL par_ren: got %0d expected 2", count_ev(1, 0, s, cyc)); else passed++;
    checks++; if (txd_log[1][st + 28] !== 1'b1) $display("FAIL par_bit07: got %b expected 1", txd_log[1][st + 28]); else passed++;
    checks++; if (txd_log[1][st + 31] !== 1'b1) $display("FAIL par_stop07: got %b expected 1", txd_log[1][st + 31]); else passed++;
    checks++; if (txd_log[1][st + 39 + 28] !== 1'b0) $display("FAIL par_bit03: got %b expected 0", txd_log[1][st + 67]); else passed++;
    checks++; if (stream_errs(1, st) !== 0) $display("FAIL par_wave: got %0d bad cycles expected 0", stream_errs(1, st)); else passed++;
  endtask

  task automatic test_random_stream(input int w, input int iters);
    int s, st, got, n, div;
    for (int it = 0; it < iters; it++) begin
      n = $urandom_range(1, 4);
      div = $urandom_range(1, 6);
      mb = {};
      repeat (n) mb.push_back(8'($urandom));
      run_stream(w, div, s, st, got);
      checks++; if (got !== n) $display("FAIL rand%0d_done: got %0d expected %0d", w, got, n); else passed++;
      checks++; if (stream_errs(w, st) !== 0) $display("FAIL rand%0d_wave: got %0d bad cycles expected 0 (div %0d)", w, stream_errs(w, st), div); else passed++;
      checks++; if (count_ev(w, 1, s, cyc) !== n) $display("FAIL rand%0d_fd: got %0d expected %0d", w, count_ev(w, 1, s, cyc), n); else passed++;
    end
  endtask

  task automatic test_empty;
    int s;
    s = cyc;
    tx_en = 1'b1;
    repeat (100) @(negedge clk);
    tx_en = 1'b0;
    checks++; if (count_ev(0, 0, s, cyc) + count_ev(1, 0, s, cyc) !== 0) $display("FAIL empty_ren: got %0d expected 0", count_ev(0, 0, s, cyc) + count_ev(1, 0, s, cyc)); else passed++;
    checks++; if (count_ev(0, 2, s, cyc) + count_ev(1, 2, s, cyc) !== 0) $display("FAIL empty_txd: got %0d low cycles expected 0", count_ev(0, 2, s, cyc) + count_ev(1, 2, s, cyc)); else passed++;
  endtask

  task automatic test_tx_en_drop;
    int s, st, got, k;
    baud_div = 16'd2;
    push(0, 8'h5A); push(0, 8'h33);
    s = cyc;
    tx_en = 1'b1;
    k = 0;
    while (k < 50 && txd0 !== 1'b0) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    wait_frames(0, 1, 200, got);
    repeat (40) @(negedge clk);
    mb = {}; mb.push_back(8'h5A); build_exp(0, 1, 2);
    st = first_ev(0, 2, s, cyc);
    checks++; if (got !== 1) $display("FAIL drop_done: got %0d expected 1", got); else passed++;
    checks++; if (count_ev(0, 0, s, cyc) !== 1) $display("FAIL drop_ren: got %0d expected 1", count_ev(0, 0, s, cyc)); else passed++;
    checks++; if (stream_errs(0, st) !== 0) $display("FAIL drop_wave: got %0d bad cycles expected 0", stream_errs(0, st)); else passed++;
    checks++; if (pend0 !== 1'b1) $display("FAIL drop_pending: got %b expected 1", pend0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy0); else passed++;
    tx_en = 1'b1;
    wait_frames(0, 1, 200, got);
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    checks++; if (got !== 1) $display("FAIL drop_drain: got %0d expected 1", got); else passed++;
  endtask

  task automatic test_reset_mid;
    int s, st, got, k;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    baud_div = 16'd4;
    push(0, b1); push(0, b2);
    tx_en = 1'b1;
    k = 0;
    while (k < 50 && txd0 !== 1'b0) begin @(negedge clk); k++; end
    checks++; if (k >= 50) $display("FAIL rstmid_start: got no start bit expected one within 50 cycles"); else passed++;
    repeat (17) @(negedge clk);   // middle of data bit 3
    checks++; if (busy0 !== 1'b1) $display("FAIL rstmid_busy_pre: got %b expected 1", busy0); else passed++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (txd0 !== 1'b1)  $display("FAIL rstmid_txd: got %b expected 1", txd0);  else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy0); else passed++;
    checks++; if (ren0 !== 1'b0)  $display("FAIL rstmid_ren: got %b expected 0", ren0);  else passed++;
    @(negedge clk);
    s = cyc;
    rst = 1'b0;
    wait_frames(0, 1, 200, got);
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    mb = {}; mb.push_back(b2); build_exp(0, 1, 4);
    st = first_ev(0, 2, s, cyc);
    checks++; if (got !== 1) $display("FAIL rstmid_done: got %0d expected 1", got); else passed++;
    checks++; if (stream_errs(0, st) !== 0) $display("FAIL rstmid_wave: got %0d bad cycles expected 0", stream_errs(0, st)); else passed++;
  endtask

  task automatic test_div_change(input int div, input int new_div, input logic [7:0] b);
    int s, st, got, k, d;
    d = (div == 0) ? 1 : div;
    baud_div = 16'(div);
    push(0, b);
    s = cyc;
    tx_en = 1'b1;
    k = 0;
    while (k < 50 && txd0 !== 1'b0) begin @(negedge clk); k++; end
    baud_div = 16'(new_div);
    wait_frames(0, 1, 200, got);
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    mb = {}; mb.push_back(b); build_exp(0, 1, div);
    st = first_ev(0, 2, s, cyc);
    checks++; if (got !== 1) $display("FAIL div%0d_done: got %0d expected 1", div, got); else passed++;
    checks++; if (stream_errs(0, st) !== 0) $display("FAIL div%0d_wave: got %0d bad cycles expected 0", div, stream_errs(0, st)); else passed++;
    checks++; if (!ev(0, 1, st + 10 * d - 1)) $display("FAIL div%0d_len: got no frame_done at cycle %0d expected one", div, 10 * d - 1); else passed++;
  endtask

  initial begin
    push_v0 = 1'b0; push_v1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_random_stream(0, 3);
    test_random_stream(1, 2);
    test_empty();
    test_tx_en_drop();
    test_reset_mid();
    test_div_change(0, 7, 8'h80);
    test_div_change(3, 9, 8'($urandom));
    checks++; if (under0 + under1 !== 0) $display("FAIL empty_pop: got %0d reads of an empty FIFO expected 0", under0 + under1); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Serial transmit stage sitting directly downstream of syn_fifo in the 8051 serial-port path.
- Pops bytes from the FIFO read port with a single-cycle r_en pulse and captures r_data.
- Serialises each byte onto txd as an asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
- Bit time is runtime-programmable, as the 8051 timer-driven baud rate is.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the FIFO.
- ADDR_WIDTH, 4, FIFO address width; sizes data_avail.
- DIV_WIDTH, 16, width of the baud divisor.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- tx_en  in  1  permits fetching new frames.
- baud_div  in  DIV_WIDTH  clocks per bit; latched at frame load.
- is_empty  in  1  FIFO empty flag.
- data_avail  in  ADDR_WIDTH+1  FIFO occupancy; used only for the tx_pending status output.
- r_data  in  DATA_WIDTH  FIFO read data, valid the cycle after r_en.
- r_en  out  1  FIFO read strobe, single-cycle pulse.
- txd  out  1  serial line, idle high.
- tx_busy  out  1  high from the fetch cycle through the last stop-bit cycle.
- frame_done  out  1  one-cycle pulse in the final cycle of the last stop bit.
- tx_pending  out  1  high when data_avail is not 0, or when a frame is busy.

Behaviour:
- Reset values on the edge after rst is sampled high: txd=1, r_en=0, tx_busy=0, frame_done=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame; txd returns high on that same edge.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: when tx_en=1 and is_empty=0, assert r_en for exactly one cycle and go to FETCH. Otherwise r_en=0.
- r_en is never asserted while is_empty=1 or outside IDLE.
- FETCH: r_en=0. FIFO presents r_data. Go to LOAD.
- LOAD:
  - shift register <= r_data.
  - div_latched <= max(baud_div, 1); baud_div=0 is treated as 1.
  - Compute parity as the XOR of all data bits.
  - Go to START.
- START: txd=0 for div_latched cycles.
- DATA: txd = shift[0]; shift right every div_latched cycles; bit counter runs 0..DATA_WIDTH-1.
- PARITY: present only if PARITY_EN=1. txd = XOR of the data bits, so the total count of ones is even. Lasts div_latched cycles.
- STOP: txd=1 for STOP_BITS*div_latched cycles. frame_done pulses in the final cycle, then the state returns to IDLE.
- Bit timer: counts 0..div_latched-1. Bit/state advance happens on the terminal count. Timer width is DIV_WIDTH with no overflow, because div_latched ≤ 2^DIV_WIDTH-1.
- Frame length is (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*div_latched cycles.
- Back-to-back frames: minimum inter-frame gap is 3 idle-high cycles (IDLE, FETCH, LOAD) between the last stop-bit cycle and the next start bit.
- tx_en deasserted mid-frame: the current frame completes; no further fetch happens.
- baud_div changed mid-frame: no effect until the next LOAD.
- FIFO becomes empty mid-frame: no effect; stay in IDLE after STOP.
- tx_busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams.
  - frame-length function.
  - parity function.
- One natural sub-module, baud_tick_gen: a loadable down-counter emitting a bit_tick on terminal count.
- The FSM and shift register stay in uart_tx_drain.
- Top-level wiring: syn_fifo.r_en <= uart_tx_drain.r_en; r_data, is_empty and data_avail are fed back.

Test Plan:
- Single byte, baud_div=4, PARITY_EN=0, STOP_BITS=1. Write 0xA5 into the FIFO.
  - Expect one r_en pulse.
  - txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles).
  - One frame_done; tx_busy falls the cycle after.
- Back-to-back 0x01 then 0x02, baud_div=2. Expect exactly 2 r_en pulses and a 3-cycle idle-high gap between frames. Decoded bytes must be 0x01 then 0x02.
- Parity, PARITY_EN=1, bytes 0x07 and 0x03. Expect parity bit 1 for 0x07 and 0 for 0x03, each followed by the stop bit.
- Empty/disabled:
  - FIFO empty: r_en stays 0 and txd stays 1 for 100 cycles.
  - tx_en dropped mid-frame of 0x5A: frame completes and no second fetch occurs, though the FIFO still holds 0x33.
- Reset mid-frame: assert rst during DATA bit 3. On the next edge txd=1, tx_busy=0, r_en=0. After release, the next FIFO byte transmits cleanly.
- baud_div=0: transmit 0x80. Expect 1 cycle per bit and a 10-cycle frame; changing baud_div mid-frame has no effect on the current frame.
